// File: rtl/nrisc_fetch_decode.sv
// Nrisc fetch/decode front end.
// Fetches one byte-wide instruction per transaction over a req/ack memory
// handshake, latches it into the instruction register and presents the
// decoded fields downstream over valid/ready. Supports branch flush, a halt
// opcode and an ack timeout with automatic retry.
module nrisc_fetch_decode #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [3:0] HALT_OP     = 4'hF,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    input  logic       ready,
    input  logic       flush,
    input  logic [7:0] flush_target,
    output logic       valid,
    output logic [3:0] opcode,
    output logic [1:0] rd,
    output logic [1:0] rs,
    output logic [1:0] imm,
    output logic [7:0] pc_out,
    output logic       halted,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_DECODE = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    // The counter value seen during the last permitted WAIT cycle; the next
    // ack-less edge would be the ACK_TIMEOUT-th one.
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic [7:0] pc_reg, pc_next;
    logic [7:0] ir_reg, ir_next;
    logic [7:0] pc_out_reg, pc_out_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       terr_reg, terr_next;

    // State register and datapath registers; reset aborts any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_FETCH;
            pc_reg     <= RESET_PC;
            ir_reg     <= 8'h00;
            pc_out_reg <= 8'h00;
            cnt_reg    <= 8'h00;
            terr_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            pc_out_reg <= pc_out_next;
            cnt_reg    <= cnt_next;
            terr_reg   <= terr_next;
        end
    end

    // Next-state and datapath update; flush overrides everything except HALT.
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        pc_out_next = pc_out_reg;
        cnt_next    = cnt_reg;
        terr_next   = terr_reg;

        case (state_reg)
            S_FETCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ack) begin
                    ir_next     = mem_data;
                    pc_out_next = pc_reg;
                    cnt_next    = 8'h00;
                    state_next  = S_DECODE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    // Give up on this request: one idle cycle in FETCH, then retry same PC.
                    terr_next  = 1'b1;
                    cnt_next   = 8'h00;
                    state_next = S_FETCH;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_DECODE: begin
                if (ready) begin
                    if (ir_reg[7:4] == HALT_OP) begin
                        state_next = S_HALT;
                    end else begin
                        pc_next    = pc_reg + 8'd1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
        endcase

        // A taken branch discards any ack in flight and redirects the fetch.
        if (flush && (state_reg != S_HALT)) begin
            pc_next     = flush_target;
            ir_next     = ir_reg;
            pc_out_next = pc_out_reg;
            cnt_next    = 8'h00;
            state_next  = S_FETCH;
        end
    end

    assign mem_req     = (state_reg == S_WAIT);
    assign mem_addr    = pc_reg;
    assign valid       = (state_reg == S_DECODE);
    assign halted      = (state_reg == S_HALT);
    assign timeout_err = terr_reg;
    assign opcode      = ir_reg[7:4];
    assign rd          = ir_reg[3:2];
    assign rs          = ir_reg[1:0];
    assign imm         = ir_reg[1:0];
    assign pc_out      = pc_out_reg;

endmodule

// File: tb/tb_nrisc_fetch_decode.sv
// Self-checking bench for nrisc_fetch_decode: directed scenarios plus a
// randomized instruction stream checked against a transaction-level model
// (expected PC and expected instruction byte from a memory image).
module tb_nrisc_fetch_decode;

    localparam logic [7:0] RESET_PC    = 8'h00;
    localparam logic [3:0] HALT_OP     = 4'hF;
    localparam int         ACK_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_data = 8'h00;
    logic       ready = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] flush_target = 8'h00;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       valid;
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] imm;
    logic [7:0] pc_out;
    logic       halted;
    logic       timeout_err;

    nrisc_fetch_decode #(
        .RESET_PC    (RESET_PC),
        .HALT_OP     (HALT_OP),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .ready        (ready),
        .flush        (flush),
        .flush_target (flush_target),
        .valid        (valid),
        .opcode       (opcode),
        .rd           (rd),
        .rs           (rs),
        .imm          (imm),
        .pc_out       (pc_out),
        .halted       (halted),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state: memory image, expected PC, last loaded IR / pc_out.
    logic [7:0] mem [256];
    logic [7:0] mpc;
    logic [7:0] last_ir;
    logic [7:0] last_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One full instruction: request, optional wait states, ack, optional
    // stall with stray acks, then accept (optionally together with a flush).
    task automatic run_instr(input int waits, input int stall, input bit flush_acc,
                             input logic [7:0] tgt);
        bit         ok;
        logic [7:0] d;
        bit         exp_halt;
        wait_req(ok);
        chk("req_seen", 32'(ok), 1);
        chk("req_addr", 32'(mem_addr), 32'(mpc));
        chk("valid_in_wait", 32'(valid), 0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("req_held", 32'(mem_req), 1);
            chk("addr_held", 32'(mem_addr), 32'(mpc));
        end
        d = mem[mpc];
        mem_ack = 1'b1;
        mem_data = d;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_data = 8'($urandom);
        chk("valid_after_ack", 32'(valid), 1);
        chk("opcode", 32'(opcode), 32'(d[7:4]));
        chk("rd", 32'(rd), 32'(d[3:2]));
        chk("rs", 32'(rs), 32'(d[1:0]));
        chk("imm", 32'(imm), 32'(d[1:0]));
        chk("pc_out", 32'(pc_out), 32'(mpc));
        chk("req_after_ack", 32'(mem_req), 0);
        last_ir = d;
        last_pc = mpc;
        ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            // Acks outside WAIT must be ignored.
            mem_ack = 1'($urandom_range(0, 1));
            mem_data = 8'($urandom);
            @(negedge clk);
            chk("stall_valid", 32'(valid), 1);
            chk("stall_opcode", 32'(opcode), 32'(d[7:4]));
            chk("stall_rd", 32'(rd), 32'(d[3:2]));
            chk("stall_rs", 32'(rs), 32'(d[1:0]));
            chk("stall_pc_out", 32'(pc_out), 32'(mpc));
            chk("stall_no_req", 32'(mem_req), 0);
        end
        mem_ack = 1'b0;
        ready = 1'b1;
        if (flush_acc) begin
            flush = 1'b1;
            flush_target = tgt;
        end
        @(negedge clk);
        ready = 1'b0;
        flush = 1'b0;
        exp_halt = !flush_acc && (d[7:4] == HALT_OP);
        chk("valid_after_accept", 32'(valid), 0);
        chk("req_after_accept", 32'(mem_req), 0);
        chk("halted", 32'(halted), 32'(exp_halt));
        if (flush_acc) mpc = tgt;
        else if (!exp_halt) mpc = mpc + 8'd1;
    endtask

    // Flush during WAIT, optionally coinciding with an ack that must be dropped.
    task automatic flush_wait(input bit with_ack, input logic [7:0] tgt);
        bit ok;
        wait_req(ok);
        chk("fw_req_seen", 32'(ok), 1);
        chk("fw_req_addr", 32'(mem_addr), 32'(mpc));
        mem_ack = with_ack;
        mem_data = mem[mpc] ^ 8'h5A;
        flush = 1'b1;
        flush_target = tgt;
        @(negedge clk);
        mem_ack = 1'b0;
        flush = 1'b0;
        chk("fw_valid", 32'(valid), 0);
        chk("fw_req", 32'(mem_req), 0);
        chk("fw_ir_kept", 32'(opcode), 32'(last_ir[7:4]));
        chk("fw_rs_kept", 32'(rs), 32'(last_ir[1:0]));
        chk("fw_pc_out_kept", 32'(pc_out), 32'(last_pc));
        mpc = tgt;
    endtask

    task automatic check_reset_values();
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        chk("rst_opcode", 32'(opcode), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_rs", 32'(rs), 0);
        chk("rst_imm", 32'(imm), 0);
        chk("rst_pc_out", 32'(pc_out), 0);
        chk("rst_addr", 32'(mem_addr), 32'(RESET_PC));
    endtask

    initial begin
        bit ok;
        int r;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            if (mem[i][7:4] == HALT_OP) mem[i] = mem[i] ^ 8'h10;
        end
        mem[0] = 8'h4B;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        mpc = RESET_PC;
        last_ir = 8'h00;
        last_pc = 8'h00;

        // First instruction 8'h4B at address 0, then one with wait states and a 5-cycle stall
        run_instr(0, 0, 1'b0, 8'h00);
        run_instr(2, 5, 1'b0, 8'h00);

        // Flush coinciding with ack
        flush_wait(1'b1, 8'h20);
        run_instr(0, 0, 1'b0, 8'h00);

        // Reset mid-transaction drops the request immediately
        wait_req(ok);
        chk("mid_req_seen", 32'(ok), 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        mpc = RESET_PC;
        last_ir = 8'h00;
        last_pc = 8'h00;

        // Ack timeout: 15 WAIT cycles, one idle cycle, retry at same address
        wait_req(ok);
        chk("to_req_seen", 32'(ok), 1);
        chk("to_terr_before", 32'(timeout_err), 0);
        for (int i = 0; i < ACK_TIMEOUT - 1; i++) begin
            @(negedge clk);
            chk("to_req_high", 32'(mem_req), 1);
            chk("to_terr_low", 32'(timeout_err), 0);
        end
        @(negedge clk);
        chk("to_req_dropped", 32'(mem_req), 0);
        chk("to_terr_set", 32'(timeout_err), 1);
        @(negedge clk);
        chk("to_req_retry", 32'(mem_req), 1);
        chk("to_addr_retry", 32'(mem_addr), 32'(mpc));
        run_instr(1, 0, 1'b0, 8'h00);
        chk("to_terr_sticky", 32'(timeout_err), 1);

        // PC wrap: flush at accept to 8'hFF, run the instruction there, next fetch at 0
        run_instr(0, 0, 1'b1, 8'hFF);
        run_instr(0, 1, 1'b0, 8'h00);
        chk("wrap_model", 32'(mpc), 0);
        run_instr(0, 0, 1'b0, 8'h00);

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) flush_wait(1'($urandom_range(0, 1)), 8'($urandom));
            else run_instr($urandom_range(0, 10), $urandom_range(0, 3), r == 1, 8'($urandom));
        end

        // Halt: instruction 8'hF0 at 0x40
        mem[8'h40] = 8'hF0;
        run_instr(0, 0, 1'b1, 8'h40);
        run_instr(0, 2, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            flush = (i % 5 == 0);
            flush_target = 8'($urandom);
            @(negedge clk);
            chk("halt_no_req", 32'(mem_req), 0);
            chk("halt_stays", 32'(halted), 1);
            chk("halt_no_valid", 32'(valid), 0);
        end
        flush = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        mpc = RESET_PC;
        last_ir = 8'h00;
        last_pc = 8'h00;
        run_instr(0, 0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
